// File: rtl/arbitro_pkg.sv
// arbitro_pkg -- shared types and helpers for the bus-ownership controller that
// sits behind the arbitro request arbiter.
//   N_DEV      : number of requesting devices
//   dev_vec_t  : one bit per device (requests, grants, acks, done strobes)
//   dev_idx_t  : encoded device index
//   estado_t   : ownership FSM states
//   grant_ok() : combinational consistency check of an arbiter grant
package arbitro_pkg;

  localparam int N_DEV = 4;

  typedef logic [N_DEV-1:0]         dev_vec_t;
  typedef logic [$clog2(N_DEV)-1:0] dev_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } estado_t;

  // A grant is trusted only when the vector is one-hot, agrees with the encoded
  // index, and the granted device is actually requesting.
  function automatic logic grant_ok(input dev_vec_t grant,
                                    input dev_idx_t idx,
                                    input dev_vec_t req);
    logic one_hot;
    one_hot  = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    grant_ok = one_hot && grant[idx] && req[idx];
  endfunction

endpackage

// File: rtl/contador_hold.sv
// contador_hold -- 8-bit saturating ownership-duration counter.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over en
//   en    : count up by one, sticking at 255
//   count : current count
module contador_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count
);

  logic [7:0] count_d;
  logic [7:0] count_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/controle_grant.sv
// controle_grant -- turns arbitro grants into registered bus ownership.
// A consistent grant seen in IDLE is latched into Ack/Owner_num; ownership is
// then frozen until the owner signals Done or drops its request, followed by a
// one-cycle GAP so consecutive owners are separated by at least two idle cycles.
// Build option: define CONTROLE_GRANT_TIMEOUT_EN to force release after
// MAX_HOLD ownership cycles (Timeout pulse); undefined, ownership is unbounded.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   R                   : raw device requests
//   Av, Grant, Grant_num: arbiter grant presentation
//   Done                : per-device end-of-transfer strobe
//   Ack, Owner_num      : registered one-hot owner / owner index
//   Busy                : OWN or GAP
//   Timeout             : one-cycle pulse on forced release
//   Err                 : one-cycle pulse after an inconsistent grant in IDLE
module controle_grant
  import arbitro_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] R,
  input  logic       Av,
  input  logic [3:0] Grant,
  input  logic [1:0] Grant_num,
  input  logic [3:0] Done,
  output logic [3:0] Ack,
  output logic [1:0] Owner_num,
  output logic       Busy,
  output logic       Timeout,
  output logic       Err
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  estado_t  state_d,   state_q;
  dev_vec_t ack_d,     ack_q;
  dev_idx_t owner_d,   owner_q;
  logic     busy_d,    busy_q;
  logic     timeout_d, timeout_q;
  logic     err_d,     err_q;

  logic       hold_clr_s;
  logic       hold_en_s;
  logic [7:0] hold_cnt_s;
  logic       release_s;
  logic       timeout_hit_s;

  contador_hold u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr_s),
    .en    (hold_en_s),
    .count (hold_cnt_s)
  );

  assign release_s = Done[owner_q] | ~R[owner_q];

`ifdef CONTROLE_GRANT_TIMEOUT_EN
  assign timeout_hit_s = (hold_cnt_s == HOLD_LAST);
`else
  // Counter keeps running but never forces a release in this build.
  logic unused_hold_s;
  assign unused_hold_s = ^{hold_cnt_s, HOLD_LAST};
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    err_d      = 1'b0;
    hold_clr_s = 1'b0;
    hold_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        ack_d = 4'b0000;
        if (Av) begin
          if (grant_ok(Grant, Grant_num, R)) begin
            state_d    = OWN;
            ack_d      = Grant;
            owner_d    = Grant_num;
            hold_clr_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        hold_en_s = 1'b1;
        // Owner release takes priority so a coincident timeout is not reported.
        if (release_s) begin
          state_d = GAP;
          ack_d   = 4'b0000;
        end else if (timeout_hit_s) begin
          state_d   = GAP;
          ack_d     = 4'b0000;
          timeout_d = 1'b1;
        end else begin
          state_d = OWN;
        end
      end
      GAP: begin
        state_d = IDLE;
        ack_d   = 4'b0000;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 4'b0000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ack_q     <= 4'b0000;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign Ack       = ack_q;
  assign Owner_num = owner_q;
  assign Busy      = busy_q;
  assign Timeout   = timeout_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_controle_grant.sv
// tb_controle_grant -- directed self-checking bench for controle_grant
// (instantiated with MAX_HOLD=4). Inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_controle_grant;

  logic       clk;
  logic       rst_n;
  logic [3:0] R;
  logic       Av;
  logic [3:0] Grant;
  logic [1:0] Grant_num;
  logic [3:0] Done;
  logic [3:0] Ack;
  logic [1:0] Owner_num;
  logic       Busy;
  logic       Timeout;
  logic       Err;

  int total;
  int bad;

  controle_grant #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .R         (R),
    .Av        (Av),
    .Grant     (Grant),
    .Grant_num (Grant_num),
    .Done      (Done),
    .Ack       (Ack),
    .Owner_num (Owner_num),
    .Busy      (Busy),
    .Timeout   (Timeout),
    .Err       (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic av, input logic [3:0] g,
                       input logic [1:0] n, input logic [3:0] d);
    R = r; Av = av; Grant = g; Grant_num = n; Done = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0000);
    tick();
    total++; if ({Ack, Owner_num, Busy, Timeout, Err} !== 9'd0) begin bad++;
      $display("FAIL reset_outputs got=%b exp=%b", {Ack, Owner_num, Busy, Timeout, Err}, 9'd0); end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    rst_n = 1'b1;
    tick();
    total++; if ({Ack, Busy} !== 5'd0) begin bad++;
      $display("FAIL reset_idle got=%b exp=%b", {Ack, Busy}, 5'd0); end
  endtask

  task automatic test_normal();
    drive(4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0000);
    tick();
    total++; if ({Ack, Owner_num, Busy} !== {4'b0001, 2'd0, 1'b1}) begin bad++;
      $display("FAIL normal_grant got=%b exp=%b", {Ack, Owner_num, Busy}, {4'b0001, 2'd0, 1'b1}); end
    Av = 1'b0;
    // Foreign Done bits must not end ownership.
    Done = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (Ack !== 4'b0001) begin bad++;
        $display("FAIL normal_hold got=%b exp=%b", Ack, 4'b0001); end
    end
    Done = 4'b0001;
    tick();
    total++; if ({Ack, Busy, Timeout} !== {4'b0000, 1'b1, 1'b0}) begin bad++;
      $display("FAIL normal_gap got=%b exp=%b", {Ack, Busy, Timeout}, {4'b0000, 1'b1, 1'b0}); end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    tick();
    total++; if ({Ack, Busy} !== 5'd0) begin bad++;
      $display("FAIL normal_idle got=%b exp=%b", {Ack, Busy}, 5'd0); end
  endtask

  task automatic test_frozen();
    drive(4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0000);
    tick();
    total++; if ({Ack, Owner_num} !== {4'b0100, 2'd2}) begin bad++;
      $display("FAIL frozen_grant got=%b exp=%b", {Ack, Owner_num}, {4'b0100, 2'd2}); end
    drive(4'b1100, 1'b1, 4'b1000, 2'd3, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({Ack, Owner_num} !== {4'b0100, 2'd2}) begin bad++;
        $display("FAIL frozen_hold got=%b exp=%b", {Ack, Owner_num}, {4'b0100, 2'd2}); end
    end
    R = 4'b1000;
    tick();
    total++; if ({Ack, Busy} !== {4'b0000, 1'b1}) begin bad++;
      $display("FAIL frozen_release got=%b exp=%b", {Ack, Busy}, {4'b0000, 1'b1}); end
    tick();
    total++; if ({Ack, Busy} !== 5'd0) begin bad++;
      $display("FAIL frozen_deadtime got=%b exp=%b", {Ack, Busy}, 5'd0); end
    tick();
    total++; if ({Ack, Owner_num} !== {4'b1000, 2'd3}) begin bad++;
      $display("FAIL frozen_next_owner got=%b exp=%b", {Ack, Owner_num}, {4'b1000, 2'd3}); end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    tick();
    tick();
  endtask

  task automatic test_bad_grant();
    logic [3:0] tr [3];
    logic [3:0] tg [3];
    logic [1:0] tn [3];
    tr[0] = 4'b0110; tg[0] = 4'b0110; tn[0] = 2'd1;  // not one-hot
    tr[1] = 4'b0110; tg[1] = 4'b0100; tn[1] = 2'd1;  // index disagrees
    tr[2] = 4'b0000; tg[2] = 4'b0010; tn[2] = 2'd1;  // device not requesting
    for (int i = 0; i < 3; i++) begin
      drive(tr[i], 1'b1, tg[i], tn[i], 4'b0000);
      tick();
      total++; if ({Err, Ack, Busy} !== {1'b1, 4'b0000, 1'b0}) begin bad++;
        $display("FAIL bad_grant_%0d got=%b exp=%b", i, {Err, Ack, Busy}, {1'b1, 4'b0000, 1'b0}); end
      Av = 1'b0;
      tick();
      total++; if ({Err, Ack, Busy} !== 6'd0) begin bad++;
        $display("FAIL bad_grant_clear_%0d got=%b exp=%b", i, {Err, Ack, Busy}, 6'd0); end
    end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
  endtask

  task automatic test_timeout();
    drive(4'b0010, 1'b1, 4'b0010, 2'd1, 4'b0000);
    tick();
    total++; if ({Ack, Owner_num} !== {4'b0010, 2'd1}) begin bad++;
      $display("FAIL timeout_grant got=%b exp=%b", {Ack, Owner_num}, {4'b0010, 2'd1}); end
    Av = 1'b0;
`ifdef CONTROLE_GRANT_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({Ack, Timeout} !== {4'b0010, 1'b0}) begin bad++;
        $display("FAIL timeout_hold got=%b exp=%b", {Ack, Timeout}, {4'b0010, 1'b0}); end
    end
    tick();
    total++; if ({Ack, Busy, Timeout} !== {4'b0000, 1'b1, 1'b1}) begin bad++;
      $display("FAIL timeout_fire got=%b exp=%b", {Ack, Busy, Timeout}, {4'b0000, 1'b1, 1'b1}); end
    tick();
    total++; if ({Ack, Busy, Timeout} !== 6'd0) begin bad++;
      $display("FAIL timeout_pulse_end got=%b exp=%b", {Ack, Busy, Timeout}, 6'd0); end
    // Done on the last allowed cycle is a normal release.
    drive(4'b0010, 1'b1, 4'b0010, 2'd1, 4'b0000);
    tick();
    Av = 1'b0;
    tick(); tick(); tick();
    Done = 4'b0010;
    tick();
    total++; if ({Ack, Busy, Timeout} !== {4'b0000, 1'b1, 1'b0}) begin bad++;
      $display("FAIL timeout_vs_done got=%b exp=%b", {Ack, Busy, Timeout}, {4'b0000, 1'b1, 1'b0}); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if ({Ack, Timeout} !== {4'b0010, 1'b0}) begin bad++;
        $display("FAIL unbounded_hold_%0d got=%b exp=%b", i, {Ack, Timeout}, {4'b0010, 1'b0}); end
    end
    R = 4'b0000;
    tick();
`endif
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    tick();
    total++; if ({Ack, Busy} !== 5'd0) begin bad++;
      $display("FAIL timeout_idle got=%b exp=%b", {Ack, Busy}, 5'd0); end
  endtask

  task automatic test_reset_mid();
    drive(4'b1000, 1'b1, 4'b1000, 2'd3, 4'b0000);
    tick();
    total++; if (Ack !== 4'b1000) begin bad++;
      $display("FAIL midreset_grant got=%b exp=%b", Ack, 4'b1000); end
    rst_n = 1'b0;
    tick();
    total++; if ({Ack, Owner_num, Busy, Timeout, Err} !== 9'd0) begin bad++;
      $display("FAIL midreset_clear got=%b exp=%b", {Ack, Owner_num, Busy, Timeout, Err}, 9'd0); end
    rst_n = 1'b1;
    tick();
    total++; if ({Ack, Owner_num, Busy} !== {4'b1000, 2'd3, 1'b1}) begin bad++;
      $display("FAIL midreset_reload got=%b exp=%b", {Ack, Owner_num, Busy}, {4'b1000, 2'd3, 1'b1}); end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    int         zero_run;
    zero_run = 2;
    // Bench plays a round-robin arbitro: device k is offered after owner k-1.
    for (int k = 0; k < 4; k++) begin
      exp_ack = 4'b0001 << k;
      drive(4'b1111, 1'b1, exp_ack, 2'(k), 4'b0000);
      tick();
      total++; if ({Ack, Owner_num} !== {exp_ack, 2'(k)}) begin bad++;
        $display("FAIL b2b_owner_%0d got=%b exp=%b", k, {Ack, Owner_num}, {exp_ack, 2'(k)}); end
      total++; if (zero_run < 2) begin bad++;
        $display("FAIL b2b_deadtime_%0d got=%0d exp>=%0d", k, zero_run, 2); end
      total++; if (!$onehot0(Ack)) begin bad++;
        $display("FAIL b2b_onehot_%0d got=%b exp=one-hot", k, Ack); end
      zero_run = 0;
      Done = exp_ack;
      tick();
      if (Ack == 4'b0000) zero_run++;
      Done = 4'b0000;
      tick();
      if (Ack == 4'b0000) zero_run++;
    end
    total++; if (zero_run !== 2) begin bad++;
      $display("FAIL b2b_final_gap got=%0d exp=%0d", zero_run, 2); end
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000);
    test_reset();
    test_normal();
    test_frozen();
    test_bad_grant();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
